// File: rtl/sm83_pkg.sv
// sm83_pkg: shared SM83 definitions (CB prefix, fetch state encoding, opcode length lookup)
//   Used by fetch_unit, opcode_len_decode and control.
package sm83_pkg;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    typedef enum logic [1:0] {
        FETCH_ADDR = 2'd0,
        FETCH_DATA = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

    // Total length of an unprefixed instruction; illegal opcodes are treated as 1 byte.
    function automatic logic [1:0] opcode_len(input logic [7:0] opcode);
        case (opcode)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:
                opcode_len = 2'd2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA:
                opcode_len = 2'd3;
            default:
                opcode_len = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/opcode_len_decode.sv
// opcode_len_decode: combinational opcode -> instruction length (1..3 bytes)
//   opcode  in  8  unprefixed opcode byte
//   len     out 2  total instruction length in bytes
module opcode_len_decode
    import sm83_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    assign len = opcode_len(opcode);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: SM83 instruction fetch stage; reads bytes over the shared bus and
// assembles {CB prefix, opcode, immediate} records for control.
//   clk, rst (sync, active-low)
//   bus_grant           bus usable this cycle
//   flush, flush_pc     redirect (highest priority)
//   addr_out, addr_oe   address bus drive (tri-stated above this level)
//   mem_cs, mem_oe      memory chip select / output enable
//   data_in             data bus
//   instr_valid/ready   record handshake
//   instr_opcode, instr_cb, instr_imm, instr_len, instr_pc, instr_next_pc  record
module fetch_unit
    import sm83_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_grant,
    input  logic        flush,
    input  logic [15:0] flush_pc,
    output logic [15:0] addr_out,
    output logic        addr_oe,
    output logic        mem_cs,
    output logic        mem_oe,
    input  logic [7:0]  data_in,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic        instr_cb,
    output logic [15:0] instr_imm,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    output logic [15:0] instr_next_pc
);

    fetch_state_t state, state_next;
    logic [15:0]  fetch_ptr;
    logic [1:0]   byte_cnt;
    logic [7:0]   rec_opcode;
    logic         rec_cb;
    logic [15:0]  rec_imm;
    logic [1:0]   rec_len;
    logic [15:0]  rec_pc;
    logic [1:0]   dec_len;
    logic         is_cb;
    logic         capture;
    logic         last_byte;
    logic         bus_on;

    opcode_len_decode u_len (
        .opcode (data_in),
        .len    (dec_len)
    );

    assign is_cb = data_in == CB_PREFIX;

    // Whether the byte on the bus now completes the record.
    assign last_byte = byte_cnt == 2'd0 ? (!is_cb && dec_len == 2'd1) :
                       byte_cnt == 2'd1 ? (rec_cb || rec_len == 2'd2) : 1'b1;

    assign bus_on = bus_grant && rst;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= FETCH_ADDR;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        addr_oe    = 1'b0;
        mem_cs     = 1'b0;
        mem_oe     = 1'b0;
        case (state)
            FETCH_ADDR: begin
                addr_oe = bus_on;
                mem_cs  = bus_on;
                if (bus_grant)
                    state_next = FETCH_DATA;
            end
            FETCH_DATA: begin
                addr_oe = bus_on;
                mem_cs  = bus_on;
                mem_oe  = bus_on;
                capture = bus_grant;
                // Losing the grant here drops the byte; it is re-read from ADDR.
                state_next = !bus_grant ? FETCH_ADDR : last_byte ? FETCH_HOLD : FETCH_ADDR;
            end
            FETCH_HOLD: begin
                if (instr_ready)
                    state_next = FETCH_ADDR;
            end
            default: state_next = FETCH_ADDR;
        endcase
        if (flush)
            state_next = FETCH_ADDR;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_ptr  <= RESET_PC;
            byte_cnt   <= 2'd0;
            rec_opcode <= 8'h00;
            rec_cb     <= 1'b0;
            rec_imm    <= 16'h0000;
            rec_len    <= 2'd0;
            rec_pc     <= 16'h0000;
        end else if (flush) begin
            fetch_ptr <= flush_pc;
            byte_cnt  <= 2'd0;
        end else if (capture) begin
            fetch_ptr <= fetch_ptr + 16'd1;
            byte_cnt  <= last_byte ? 2'd0 : byte_cnt + 2'd1;
            if (byte_cnt == 2'd0) begin
                rec_pc     <= fetch_ptr;
                rec_opcode <= data_in;
                rec_cb     <= is_cb;
                rec_imm    <= 16'h0000;
                rec_len    <= is_cb ? 2'd2 : dec_len;
            end else if (byte_cnt == 2'd1) begin
                // Second byte is the real opcode after CB, otherwise the low immediate.
                if (rec_cb)
                    rec_opcode <= data_in;
                else
                    rec_imm[7:0] <= data_in;
            end else begin
                rec_imm[15:8] <= data_in;
            end
        end
    end

    assign addr_out      = addr_oe ? fetch_ptr : 16'h0000;
    assign instr_valid   = state == FETCH_HOLD;
    assign instr_opcode  = rec_opcode;
    assign instr_cb      = rec_cb;
    assign instr_imm     = rec_imm;
    assign instr_len     = rec_len;
    assign instr_pc      = rec_pc;
    assign instr_next_pc = rec_pc + {14'd0, rec_len};

endmodule

// File: doc/fetch_unit.md
# fetch_unit

SM83 instruction fetch stage, directly upstream of `control`. Owns the fetch pointer and sequences byte reads from the synchronous boot ROM/memory over the shared address/data buses. Assembles each instruction (CB prefix, opcode, 0–2 immediate bytes) into one record. Hands the record to `control` over a valid/ready handshake; `control` redirects it with `flush` on jumps, calls, returns and interrupts.

## Interface
- `RESET_PC`, 16'h0000, fetch address loaded on reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `bus_grant`  in  1  `control` allows fetch to use the address/data buses this cycle.
- `flush`  in  1  redirect request; highest priority.
- `flush_pc`  in  16  new fetch address, sampled when `flush`=1.
- `addr_out`  out  16  memory address; tri-stated at top level when `addr_oe`=0.
- `addr_oe`  out  1  fetch drives the address bus.
- `mem_cs`  out  1  memory chip select.
- `mem_oe`  out  1  memory drives the data bus this cycle.
- `data_in`  in  8  data bus.
- `instr_valid`  out  1  record valid.
- `instr_ready`  in  1  `control` accepts the record.
- `instr_opcode`  out  8  opcode; the second byte when CB-prefixed.
- `instr_cb`  out  1  CB-prefixed instruction.
- `instr_imm`  out  16  immediate: imm8 zero-extended, imm16 little-endian, else 0.
- `instr_len`  out  2  total length in bytes (1–3; CB = 2).
- `instr_pc`  out  16  address of the first byte.
- `instr_next_pc`  out  16  `instr_pc + instr_len`, mod 2^16.

## Operation
- States:
  - ADDR: drive `addr_out` = fetch_ptr, `addr_oe` = `mem_cs` = 1.
  - DATA: same address held, plus `mem_oe` = 1; `data_in` captured at the end of the cycle.
  - HOLD: `instr_valid` = 1; bus outputs 0.
- Bus outputs are asserted only while `bus_grant` = 1.
- Transitions:
  - ADDR → DATA when `bus_grant` = 1; otherwise stay in ADDR.
  - DATA with `bus_grant` = 0 → ADDR. The byte is discarded, the pointer is unchanged, and the byte is re-fetched.
  - DATA with a captured byte: fetch_ptr += 1 (16-bit wrap, FFFF → 0000). Go to ADDR if more bytes are needed, else to HOLD.
  - HOLD with `instr_ready` = 1 → ADDR at fetch_ptr (= `instr_next_pc`).
- Byte sequencing:
  - Byte 0 = CB → fetch one more byte as the opcode; `instr_cb` = 1, len 2, no immediate.
  - Otherwise byte 0 is the opcode and the length comes from the length table.
  - Length 2 opcodes: 06 0E 16 1E 26 2E 36 3E 10 18 20 28 30 38 C6 CE D6 DE E6 EE F6 FE E0 F0 E8 F8.
  - Length 3 opcodes: 01 11 21 31 08 C2 C3 CA D2 DA C4 CC CD D4 DC EA FA.
  - All other opcodes, including the illegal ones, are length 1.
- Record fields are stable throughout HOLD.
- `flush` = 1 at any edge, in any state:
  - fetch_ptr ← `flush_pc`, state ← ADDR, and any partial or held record is dropped.
  - If valid & ready & flush occur in the same cycle, the handshake counts as a transfer and the pointer still takes `flush_pc`.
- Reset (`rst` = 0 at an edge): state ADDR, fetch_ptr = `RESET_PC`, all record registers 0, `instr_valid` = 0.
  - While `rst` = 0, `addr_oe`/`mem_cs`/`mem_oe` are forced to 0.
  - Reset mid-instruction discards the instruction.

## Timing
- Memory read latency is 1 cycle: the address is held in ADDR and the data is valid in DATA. Each byte costs 2 cycles.
- With cycle 0 = first ADDR cycle and grant held high, `instr_valid` first rises in:
  - cycle 2 for len 1;
  - cycle 4 for len 2 or CB;
  - cycle 6 for len 3.
- Accept at the end of cycle k → ADDR in cycle k+1. Steady-state rate is 1 NOP per 3 cycles.
- Each cycle with `bus_grant` = 0 in ADDR adds 1 cycle. A grant loss in DATA adds that cycle plus 1.
- Flush latency is 1 cycle: `addr_out` = `flush_pc` in the cycle after the flush edge, and `instr_valid` = 0 in that same cycle.

## Structure
- Shared package `sm83_pkg` holds:
  - `CB_PREFIX` = 8'hCB;
  - the fetch state encoding (ADDR/DATA/HOLD);
  - the opcode length function.
- Sub-module `opcode_len_decode`: combinational, 8-bit opcode → 2-bit length. It is reused by `control`.
- The top-level wrapper provides the tri-state of `addr_out` onto `addr_bus`.

## Test plan
- **Reset:** hold `rst` = 0 for 2 edges, mem[0000] = 00.
  - Expect cycle 0 `addr_out` = 0000 and `addr_oe` = 1.
  - Expect cycle 2 valid, opcode 00, len 1, pc 0000, next 0001.
- **Three-byte instruction:** mem[0..2] = 31 FE FF → cycle 6 valid, opcode 31, imm FFFE, len 3, next 0003.
- **CB prefix:** mem = CB 7C → valid in cycle 4, `instr_cb` = 1, opcode 7C, len 2, imm 0000.
- **Backpressure:** hold `instr_ready` low for 5 cycles in HOLD.
  - Record stays stable; `addr_oe`/`mem_cs`/`mem_oe` stay 0.
  - After ready rises, the next cycle shows `addr_out` = 0001.
- **Flush:** flush to 0100 while fetching the C3 immediate.
  - Next cycle `addr_out` = 0100; the C3 record is never valid.
  - A flush during HOLD drops valid the next cycle.
- **Wrap and grant:** 1-byte opcode at FFFF gives `instr_next_pc` = 0000. Dropping `bus_grant` for 2 cycles in DATA re-fetches the same address, and valid appears 3 cycles late.
